simd_job_scheduler: RTL and testbench

Sequencer and arbiter in front of the 4×4 SIMD matrix-multiply array.
- Accepts multiply jobs (packed A and B operands) from two requesters and grants them round-robin.
- Per job: clears the PE accumulators, holds the array enabled for a fixed number of cycles, captures Matrix_C and returns it with the requester ID over a valid/ready handshake.
- Only one job is in the array at a time; the block is the array's sole owner of its reset and enable pins.

---
 rtl/simd_pkg.sv | 20 ++
 rtl/simd_job_scheduler_if.sv | 27 ++
 rtl/simd_job_scheduler_arb.sv | 36 +++
 rtl/simd_job_scheduler.sv | 137 +++++++++++++
 tb/tb_simd_job_scheduler.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_pkg.sv
// Shared constants, FSM state type and small helpers for the SIMD job scheduler.
package simd_pkg;

    localparam int MAT_W          = 336;
    localparam int ROW_W          = 84;
    localparam int ELEM_W         = 21;
    localparam int DEF_PE_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/simd_job_scheduler_if.sv
// Job-side bundle: two requester channels in, one result channel out.
interface simd_job_scheduler_if #(
    parameter int W = simd_pkg::MAT_W
) ();

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_c;
    logic         out_id;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, out_ready,
        input  req_ready, out_valid, out_c, out_id
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, out_ready,
        output req_ready, out_valid, out_c, out_id
    );

endinterface

// File: rtl/simd_job_scheduler_arb.sv
// Two-input round-robin arbiter; last_grant moves only when the grant is accepted.
module rr_arbiter2
    import simd_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       winner
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        // Contention goes to whoever was not served last.
        winner = ~last_grant_q;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
        grant        = (req == 2'b00) ? 2'b00 : idx_onehot(winner);
        last_grant_d = accept ? winner : last_grant_q;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/simd_job_scheduler.sv
// Sequencer in front of the 4x4 SIMD array: arbitrates jobs, clears and runs the
// array for PE_LATENCY cycles, then holds the captured Matrix_C until accepted.
module simd_job_scheduler
    import simd_pkg::*;
#(
    parameter int PE_LATENCY = DEF_PE_LATENCY
) (
    input  logic                 CLK,
    input  logic                 reset,
    simd_job_scheduler_if.slave  jobs,
    output logic                 simd_reset,
    output logic                 simd_enable,
    output logic [MAT_W-1:0]     simd_a,
    output logic [MAT_W-1:0]     simd_b,
    input  logic [MAT_W-1:0]     simd_c,
    output logic                 busy
);

    localparam int               CNT_W    = $clog2(PE_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PE_LATENCY - 1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAT_W-1:0] simd_a_q, simd_a_d;
    logic [MAT_W-1:0] simd_b_q, simd_b_d;
    logic [MAT_W-1:0] out_c_q, out_c_d;
    logic             out_id_q, out_id_d;
    logic             simd_reset_q, simd_reset_d;
    logic             simd_enable_q, simd_enable_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [1:0] grant;
    logic       winner;
    logic       idle;
    logic       accept;

    assign idle   = (state_q == IDLE);
    assign accept = idle && ((jobs.req_valid & grant) != 2'b00);

    rr_arbiter2 u_arb (
        .CLK    (CLK),
        .reset  (reset),
        .req    (jobs.req_valid),
        .accept (accept),
        .grant  (grant),
        .winner (winner)
    );

    assign jobs.req_ready = idle ? grant : 2'b00;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch below can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        simd_a_d = simd_a_q;
        simd_b_d = simd_b_q;
        out_c_d  = out_c_q;
        out_id_d = out_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = CLEAR;
                    simd_a_d = winner ? jobs.req_a1 : jobs.req_a0;
                    simd_b_d = winner ? jobs.req_b1 : jobs.req_b0;
                    out_id_d = winner;
                end
            end
            CLEAR: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    out_c_d = simd_c;
                end
            end
            DONE: begin
                if (jobs.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        simd_reset_d = simd_reset_q;
        if (state_d == CLEAR) begin
            simd_reset_d = 1'b0;
        end else if (state_d == RUN) begin
            simd_reset_d = 1'b1;
        end
        simd_enable_d = (state_d == RUN);
        out_valid_d   = (state_d == DONE);
        busy_d        = (state_d != IDLE);
    end

    // NOTE: state uses non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            simd_a_q      <= '0;
            simd_b_q      <= '0;
            out_c_q       <= '0;
            out_id_q      <= 1'b0;
            simd_reset_q  <= 1'b0;
            simd_enable_q <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            simd_a_q      <= simd_a_d;
            simd_b_q      <= simd_b_d;
            out_c_q       <= out_c_d;
            out_id_q      <= out_id_d;
            simd_reset_q  <= simd_reset_d;
            simd_enable_q <= simd_enable_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign simd_reset     = simd_reset_q;
    assign simd_enable    = simd_enable_q;
    assign simd_a         = simd_a_q;
    assign simd_b         = simd_b_q;
    assign busy           = busy_q;
    assign jobs.out_valid = out_valid_q;
    assign jobs.out_c     = out_c_q;
    assign jobs.out_id    = out_id_q;

endmodule

// File: tb/tb_simd_job_scheduler.sv
// Bench for simd_job_scheduler: three instances (PE_LATENCY 4, 1, 7) share stimulus;
// a behavioural array model supplies Matrix_C only on the cycle it is valid.
module tb_simd_job_scheduler;
    import simd_pkg::*;

    localparam int NDUT     = 3;
    localparam int MAIN_LAT = 4;

    function automatic int lat_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 7);
    endfunction

    logic             CLK = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [MAT_W-1:0] a0, b0, a1, b1;
    logic             out_ready;

    logic             en_w   [NDUT];
    logic             rst_w  [NDUT];
    logic             ov_w   [NDUT];
    logic             busy_w [NDUT];
    logic             id_w   [NDUT];
    logic [1:0]       rr_w   [NDUT];
    logic [MAT_W-1:0] oc_w   [NDUT];
    logic [MAT_W-1:0] sa_w   [NDUT];
    logic [MAT_W-1:0] sb_w   [NDUT];
    logic [MAT_W-1:0] sc_w   [NDUT];
    int               arr_cnt[NDUT];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int both_hi  = 0;
    int gq[$];
    logic lg_m;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 7);
        simd_job_scheduler_if u_if ();
        assign u_if.req_valid = req_valid;
        assign u_if.req_a0    = a0;
        assign u_if.req_b0    = b0;
        assign u_if.req_a1    = a1;
        assign u_if.req_b1    = b1;
        assign u_if.out_ready = out_ready;
        assign rr_w[g]        = u_if.req_ready;
        assign ov_w[g]        = u_if.out_valid;
        assign oc_w[g]        = u_if.out_c;
        assign id_w[g]        = u_if.out_id;
        simd_job_scheduler #(.PE_LATENCY(L)) u_dut (
            .CLK         (CLK),
            .reset       (reset),
            .jobs        (u_if),
            .simd_reset  (rst_w[g]),
            .simd_enable (en_w[g]),
            .simd_a      (sa_w[g]),
            .simd_b      (sb_w[g]),
            .simd_c      (sc_w[g]),
            .busy        (busy_w[g])
        );
    end

    function automatic logic [ELEM_W-1:0] el(input logic [MAT_W-1:0] m, input int r, input int c);
        return m[(r*4 + c)*ELEM_W +: ELEM_W];
    endfunction

    function automatic logic [MAT_W-1:0] matmul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        logic [MAT_W-1:0]    c;
        logic [ELEM_W-1:0]   acc;
        logic [2*ELEM_W-1:0] p;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            for (int cc = 0; cc < 4; cc++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    p   = el(a, r, k) * el(b, k, cc);
                    acc = acc + p[ELEM_W-1:0];
                end
                c[(r*4 + cc)*ELEM_W +: ELEM_W] = acc;
            end
        end
        return c;
    endfunction

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < 16; i++) m[i*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] fill_mat(input bit ident, input int v);
        logic [MAT_W-1:0] m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(r*4 + c)*ELEM_W +: ELEM_W] = ident ? ELEM_W'(r == c) : ELEM_W'(v);
        return m;
    endfunction

    // Specification arbitration rule: lone requester wins; on contention, the one not served last.
    function automatic logic arbitrate(input logic [1:0] v, input logic lg);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
        return (lg == 1'b1) ? 1'b0 : 1'b1;
    endfunction

    // Array model: accumulators clear on simd_reset low; Matrix_C is only correct on the
    // enabled cycle that follows PE_LATENCY-1 enabled edges, garbage otherwise.
    always @(posedge CLK) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rst_w[g] !== 1'b1) arr_cnt[g] <= 0;
            else if (en_w[g] === 1'b1) arr_cnt[g] <= arr_cnt[g] + 1;
        end
    end

    always_comb begin
        for (int g = 0; g < NDUT; g++) begin
            sc_w[g] = ~matmul(sa_w[g], sb_w[g]);
            if (en_w[g] === 1'b1 && arr_cnt[g] == lat_of(g) - 1) sc_w[g] = matmul(sa_w[g], sb_w[g]);
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (reset === 1'b1 && (rr_w[0] & req_valid) !== 2'b00 && (rr_w[0] & req_valid) !== 2'bxx)
            gq.push_back(cyc);
        if (rr_w[0] === 2'b11) both_hi <= both_hi + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        lg_m  = 1'b1;
    endtask

    // Grants the current request on the main instance and checks the CLEAR cycle.
    task automatic serve_one(input string tag, output logic [MAT_W-1:0] exp_c, output logic exp_id);
        logic [MAT_W-1:0] ea, eb;
        #1;
        exp_id = arbitrate(req_valid, lg_m);
        ea     = exp_id ? a1 : a0;
        eb     = exp_id ? b1 : b0;
        exp_c  = matmul(ea, eb);
        checks++;
        if (rr_w[0] !== idx_onehot(exp_id)) begin
            failures++;
            $display("FAIL %s_ready got=%b exp=%b", tag, rr_w[0], idx_onehot(exp_id));
        end
        step();
        lg_m = exp_id;
        checks++;
        if ({busy_w[0], rst_w[0], en_w[0]} !== 3'b100) begin
            failures++;
            $display("FAIL %s_clear got busy/rst/en=%b exp=100", tag, {busy_w[0], rst_w[0], en_w[0]});
        end
        checks++;
        if (sa_w[0] !== ea || sb_w[0] !== eb) begin
            failures++;
            $display("FAIL %s_operands got a=%h exp a=%h", tag, sa_w[0], ea);
        end
    endtask

    // From CLEAR, waits for DONE and checks latency, enable count, result and id.
    task automatic collect(input string tag, input logic [MAT_W-1:0] exp_c, input logic exp_id);
        int n  = 1;
        int en = 0;
        while (ov_w[0] !== 1'b1 && n < 40) begin
            if (en_w[0] === 1'b1) en++;
            step();
            n++;
        end
        checks++;
        if (n != MAIN_LAT + 2) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", tag, n, MAIN_LAT + 2);
        end
        checks++;
        if (en != MAIN_LAT) begin
            failures++;
            $display("FAIL %s_enable_count got=%0d exp=%0d", tag, en, MAIN_LAT);
        end
        checks++;
        if (oc_w[0] !== exp_c || id_w[0] !== exp_id) begin
            failures++;
            $display("FAIL %s_result got id=%b c=%h exp id=%b c=%h", tag, id_w[0], oc_w[0], exp_id, exp_c);
        end
        checks++;
        if (en_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_outputs got en=%b busy=%b exp en=0 busy=1", tag, en_w[0], busy_w[0]);
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (ov_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL %s_release got ov=%b busy=%b exp 0 0", tag, ov_w[0], busy_w[0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
        a0 = rand_mat(); b0 = rand_mat(); a1 = rand_mat(); b1 = rand_mat();
        repeat (3) step();
        checks++;
        if ({busy_w[0], en_w[0], rst_w[0], ov_w[0], id_w[0]} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy/en/rst/ov/id=%b exp=00000",
                     {busy_w[0], en_w[0], rst_w[0], ov_w[0], id_w[0]});
        end
        checks++;
        if (sa_w[0] !== '0 || sb_w[0] !== '0 || oc_w[0] !== '0) begin
            failures++;
            $display("FAIL reset_data got nonzero a/b/c exp=0");
        end
        checks++;
        if (rr_w[0] !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready_idle got=%b exp=00", rr_w[0]);
        end
        req_valid = 2'b11; #1;
        checks++;
        if (rr_w[0] !== 2'b01) begin
            failures++;
            $display("FAIL reset_first_contention got=%b exp=01", rr_w[0]);
        end
        req_valid = 2'b10; #1;
        checks++;
        if (rr_w[0] !== 2'b10) begin
            failures++;
            $display("FAIL reset_lone_req1 got=%b exp=10", rr_w[0]);
        end
        req_valid = 2'b00;
        reset     = 1'b1;
        lg_m      = 1'b1;
    endtask

    task automatic test_single();
        logic [MAT_W-1:0] ec;
        logic             eid;
        apply_reset();
        a0 = fill_mat(1'b1, 0);
        b0 = fill_mat(1'b0, 3);
        req_valid = 2'b01;
        serve_one("single", ec, eid);
        req_valid = 2'b00;
        collect("single", ec, eid);
        checks++;
        if (oc_w[0] !== b0 || id_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_identity got id=%b c=%h exp id=0 c=%h", id_w[0], oc_w[0], b0);
        end
        release_result("single");
    endtask

    task automatic test_contention();
        logic [MAT_W-1:0] ec;
        logic             eid;
        logic             ids [3];
        logic             exp_order [3] = '{1'b0, 1'b1, 1'b0};
        apply_reset();
        a0 = rand_mat(); b0 = rand_mat(); a1 = rand_mat(); b1 = rand_mat();
        req_valid = 2'b11;
        for (int j = 0; j < 3; j++) begin
            serve_one("contention", ec, eid);
            if (eid) begin a1 = rand_mat(); b1 = rand_mat(); end
            else     begin a0 = rand_mat(); b0 = rand_mat(); end
            collect("contention", ec, eid);
            ids[j] = id_w[0];
            release_result("contention");
        end
        req_valid = 2'b00;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ids[j] !== exp_order[j]) begin
                failures++;
                $display("FAIL contention_order job=%0d got=%b exp=%b", j, ids[j], exp_order[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [MAT_W-1:0] ec, snap_c;
        logic             eid, snap_id;
        a1 = rand_mat(); b1 = rand_mat();
        req_valid = 2'b10;
        serve_one("bp", ec, eid);
        req_valid = 2'b11;
        collect("bp", ec, eid);
        snap_c  = ec;
        snap_id = eid;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (ov_w[0] !== 1'b1 || oc_w[0] !== snap_c || id_w[0] !== snap_id ||
                en_w[0] !== 1'b0 || rr_w[0] !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got ov=%b id=%b en=%b rdy=%b exp 1 %b 0 00",
                         k, ov_w[0], id_w[0], en_w[0], rr_w[0], snap_id);
            end
        end
        req_valid = 2'b00;
        release_result("bp");
    endtask

    task automatic test_reset_mid_run();
        logic [MAT_W-1:0] ec;
        logic             eid;
        apply_reset();
        a0 = rand_mat(); b0 = rand_mat();
        req_valid = 2'b01;
        serve_one("midrst", ec, eid);
        req_valid = 2'b00;
        step();
        step();
        checks++;
        if (en_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_in_run got en=%b exp=1", en_w[0]);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({busy_w[0], en_w[0], rst_w[0], ov_w[0], id_w[0]} !== 5'b0 ||
                sa_w[0] !== '0 || sb_w[0] !== '0 || oc_w[0] !== '0) begin
                failures++;
                $display("FAIL midrst_values cyc=%0d got busy/en/rst/ov/id=%b exp=00000",
                         k, {busy_w[0], en_w[0], rst_w[0], ov_w[0], id_w[0]});
            end
        end
        reset = 1'b1;
        lg_m  = 1'b1;
        a0 = rand_mat(); b0 = rand_mat(); a1 = rand_mat(); b1 = rand_mat();
        req_valid = 2'b11;
        serve_one("postrst", ec, eid);
        req_valid = 2'b00;
        collect("postrst", ec, eid);
        checks++;
        if (id_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL postrst_id got=%b exp=0", id_w[0]);
        end
        release_result("postrst");
    endtask

    task automatic test_sweep();
        int               en    [NDUT];
        int               first [NDUT];
        logic [MAT_W-1:0] cap   [NDUT];
        logic [MAT_W-1:0] ec;
        apply_reset();
        a0 = rand_mat(); b0 = rand_mat();
        ec = matmul(a0, b0);
        out_ready = 1'b1;
        req_valid = 2'b01;
        #1;
        for (int g = 1; g < NDUT; g++) begin
            checks++;
            if (rr_w[g] !== 2'b01) begin
                failures++;
                $display("FAIL sweep_ready lat=%0d got=%b exp=01", lat_of(g), rr_w[g]);
            end
            en[g] = 0; first[g] = 0; cap[g] = '0;
        end
        step();
        req_valid = 2'b00;
        for (int n = 1; n <= 20; n++) begin
            for (int g = 1; g < NDUT; g++) begin
                if (en_w[g] === 1'b1) en[g]++;
                if (ov_w[g] === 1'b1 && first[g] == 0) begin
                    first[g] = n;
                    cap[g]   = oc_w[g];
                end
            end
            step();
        end
        out_ready = 1'b0;
        lg_m      = 1'b0;
        for (int g = 1; g < NDUT; g++) begin
            checks++;
            if (en[g] != lat_of(g)) begin
                failures++;
                $display("FAIL sweep_enable lat=%0d got=%0d exp=%0d", lat_of(g), en[g], lat_of(g));
            end
            checks++;
            if (first[g] != lat_of(g) + 2) begin
                failures++;
                $display("FAIL sweep_latency lat=%0d got=%0d exp=%0d", lat_of(g), first[g], lat_of(g) + 2);
            end
            checks++;
            if (cap[g] !== ec) begin
                failures++;
                $display("FAIL sweep_result lat=%0d got=%h exp=%h", lat_of(g), cap[g], ec);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        a1 = rand_mat(); b1 = rand_mat();
        out_ready = 1'b1;
        req_valid = 2'b10;
        gq.delete();
        for (int k = 0; k < 100 && gq.size() < 4; k++) begin
            step();
            if (ov_w[0] === 1'b1) begin
                checks++;
                if (id_w[0] !== 1'b1 || oc_w[0] !== matmul(a1, b1)) begin
                    failures++;
                    $display("FAIL b2b_result got id=%b exp=1", id_w[0]);
                end
            end
        end
        req_valid = 2'b00;
        out_ready = 1'b0;
        checks++;
        if (gq.size() < 4) begin
            failures++;
            $display("FAIL b2b_grants got=%0d exp>=4", gq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gq[i+1] - gq[i] != MAIN_LAT + 3) begin
                    failures++;
                    $display("FAIL b2b_gap idx=%0d got=%0d exp=%0d", i, gq[i+1] - gq[i], MAIN_LAT + 3);
                end
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        test_back_to_back();
        checks++;
        if (both_hi != 0) begin
            failures++;
            $display("FAIL ready_onehot got=%0d cycles with 11 exp=0", both_hi);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
